// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset/lock/settle sequencer for the VGA pixel-clock PLL
//
// Runs on the free-running board clock and walks the PLL through
// ARESET -> WAIT_LOCK -> SETTLE -> RUN, with timeout/retry and a latched FAULT.
//
// Ports:
//   clk_in        board reference clock, sole clock of this block
//   reset         synchronous active-high reset
//   pll_locked    PLL lock flag, asynchronous to clk_in
//   restart_req   one-cycle pulse, restarts the full sequence (also exits FAULT)
//   pll_areset    PLL reset, active high
//   vga_reset     VGA logic reset, active high
//   ready         high only in RUN
//   fault         high only in FAULT
//   state         current state encoding (debug)
//   relock_count  lock losses seen in RUN, saturating at 255
module pll_lock_sequencer #(
    parameter int ARESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       restart_req,
    output logic       pll_areset,
    output logic       vga_reset,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] relock_count
);

    typedef enum logic [2:0] {
        ST_ARESET    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int MAX_AT  = (ARESET_CYCLES > LOCK_TIMEOUT) ? ARESET_CYCLES : LOCK_TIMEOUT;
    localparam int CYC_MAX = (MAX_AT > SETTLE_CYCLES) ? MAX_AT : SETTLE_CYCLES;
    localparam int CW      = $clog2(CYC_MAX) + 1;

    localparam logic [CW-1:0] ARESET_LAST = CW'(ARESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [7:0]    RETRY_LIMIT = 8'(MAX_RETRIES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    retries_q, retries_d;
    logic [7:0]    relock_q, relock_d;

    logic areset_d, vga_reset_d, ready_d, fault_d;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Lock synchronizer: pll_locked crosses in from the PLL domain.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        retries_d = retries_q;
        relock_d  = relock_q;

        if (restart_req) begin
            state_d   = ST_ARESET;
            cnt_d     = '0;
            retries_d = '0;
        end else begin
            case (state_q)
                ST_ARESET: begin
                    if (cnt_q == ARESET_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retries_d = retries_q + 8'd1;
                        state_d   = (retries_d == RETRY_LIMIT) ? ST_FAULT : ST_ARESET;
                        cnt_d     = '0;
                    end
                end
                ST_SETTLE: begin
                    // Lock loss is checked first so it beats the settle terminal count.
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        retries_d = '0;
                    end
                end
                ST_RUN: begin
                    // Counter is idle here; holding it keeps it from wrapping.
                    cnt_d     = cnt_q;
                    retries_d = '0;
                    if (!locked_s) begin
                        state_d  = ST_ARESET;
                        cnt_d    = '0;
                        relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                    end
                end
                ST_FAULT: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = ST_ARESET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the state being entered and then registered,
    // so they change on the same edge as the state register.
    always_comb begin
        areset_d    = 1'b1;
        vga_reset_d = 1'b1;
        ready_d     = 1'b0;
        fault_d     = 1'b0;
        case (state_d)
            ST_WAIT_LOCK, ST_SETTLE: areset_d = 1'b0;
            ST_RUN: begin
                areset_d    = 1'b0;
                vga_reset_d = 1'b0;
                ready_d     = 1'b1;
            end
            ST_FAULT: fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_ARESET;
            cnt_q      <= '0;
            retries_q  <= '0;
            relock_q   <= '0;
            pll_areset <= 1'b1;
            vga_reset  <= 1'b1;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retries_q  <= retries_d;
            relock_q   <= relock_d;
            pll_areset <= areset_d;
            vga_reset  <= vga_reset_d;
            ready      <= ready_d;
            fault      <= fault_d;
        end
    end

    assign state        = state_q;
    assign relock_count = relock_q;

endmodule
